instr_mem_loadable: RTL and testbench

INSTR_MEM_LOADABLE -- requirements
Module: instr_mem_loadable

---
 rtl/instr_mem_loadable_if.sv | 31 +++
 rtl/instr_mem_loadable.sv | 128 ++++++++++++
 tb/tb_instr_mem_loadable.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loadable_if.sv
// Fetch port and program-load stream of the loadable instruction memory.
// The master drives requests and load words; the slave is the memory.
interface instr_mem_loadable_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;

  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_done;
  logic              ld_wrap;
  logic              busy;

  modport master (
    output fetch_req, fetch_addr, ld_start, ld_base, ld_valid, ld_data, ld_last,
    input  fetch_data, fetch_valid, ld_ready, ld_done, ld_wrap, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, ld_start, ld_base, ld_valid, ld_data, ld_last,
    output fetch_data, fetch_valid, ld_ready, ld_done, ld_wrap, busy
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Instruction memory with a one-cycle fetch port, a NOP sweep out of reset,
// and a streaming program loader that writes consecutive words from a base.
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | sweep ptr over every word writing NOP_WORD; fetches dropped
// RUN   | serve fetches; ld_start accepted here only
// LOAD  | ld_ready=1; each ld_valid writes mem[ptr] and advances ptr
module instr_mem_loadable #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input logic                 clk,
  input logic                 rst,
  instr_mem_loadable_if.slave bus
);
  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              wrap, wrap_nxt;
  logic              done, done_nxt;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              fetch_hit;
  logic [DATA_W-1:0] fetch_data_q;
  logic              fetch_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      wrap  <= wrap_nxt;
      done  <= done_nxt;
    end
  end

  // One pointer serves both the clear sweep and the load stream.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    wrap_nxt  = wrap;
    done_nxt  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr;
    mem_wdata = NOP_WORD;
    case (state)
      CLEAR: begin
        mem_we  = 1'b1;
        ptr_nxt = ptr + PTR_ONE;
        if (ptr == PTR_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.ld_start) begin
          state_nxt = LOAD;
          ptr_nxt   = bus.ld_base;
          wrap_nxt  = 1'b0;
        end
      end
      LOAD: begin
        if (bus.ld_valid) begin
          mem_we    = 1'b1;
          mem_wdata = bus.ld_data;
          ptr_nxt   = ptr + PTR_ONE;
          if (ptr == PTR_LAST) begin
            wrap_nxt = 1'b1;
          end
          if (bus.ld_last) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Array has no reset; the CLEAR sweep is its only initialisation.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign fetch_hit = (state == RUN) && bus.fetch_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_data_q  <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_hit;
      if (fetch_hit) begin
        fetch_data_q <= mem[bus.fetch_addr];
      end
    end
  end

  assign bus.fetch_data  = fetch_data_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.ld_ready    = (state == LOAD);
  assign bus.ld_done     = done;
  assign bus.ld_wrap     = wrap;
  assign bus.busy        = (state != RUN);
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: directed vector tables plus randomized loads
// checked against an array model of the memory contents.
module tb_instr_mem_loadable;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic rst;

  instr_mem_loadable_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  instr_mem_loadable #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NOP_WORD(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          phase;
    logic [7:0]  addr;
    logic [15:0] exp;
  } fvec_t;

  fvec_t       vecs[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] ld_words[$];
  int          stall_q[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h want 0x%04h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.ld_start   = 1'b0;
    bus.ld_base    = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = '0;
    bus.ld_last    = 1'b0;
  endtask

  // Pulse reset for one cycle, then time the NOP sweep. Optional ld_start
  // noise early in the sweep must be ignored.
  task automatic reset_and_clear(input bit start_noise);
    int cnt;
    bit saw_ready;
    rst = 1'b1;
    idle();
    tick();
    chk16("rst_fetch_data", bus.fetch_data, 16'h0000);
    chk1("rst_fetch_valid", bus.fetch_valid, 1'b0);
    chk1("rst_ld_ready", bus.ld_ready, 1'b0);
    chk1("rst_ld_done", bus.ld_done, 1'b0);
    chk1("rst_ld_wrap", bus.ld_wrap, 1'b0);
    chk1("rst_busy", bus.busy, 1'b1);
    rst = 1'b0;
    cnt = 0;
    saw_ready = 1'b0;
    while (bus.busy && cnt < 1000) begin
      bus.ld_start  = start_noise && (cnt < 10);
      bus.ld_base   = 8'h80;
      bus.fetch_req = start_noise && (cnt < 10);
      tick();
      cnt++;
      if (bus.ld_ready || bus.fetch_valid) saw_ready = 1'b1;
    end
    idle();
    chk_int("clear_cycles", cnt, 256);
    chk1("clear_ignores_start_fetch", saw_ready, 1'b0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
  endtask

  task automatic fetch_chk(input logic [7:0] addr, input string name);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    tick();
    chk1({name, "_valid"}, bus.fetch_valid, 1'b1);
    chk16({name, "_data"}, bus.fetch_data, ref_mem[addr]);
    bus.fetch_req = 1'b0;
  endtask

  task automatic apply_table(input int phase);
    foreach (vecs[k]) begin
      if (vecs[k].phase == phase) begin
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = vecs[k].addr;
        tick();
        chk1($sformatf("tbl%0d_valid_%02h", phase, vecs[k].addr), bus.fetch_valid, 1'b1);
        chk16($sformatf("tbl%0d_data_%02h", phase, vecs[k].addr), bus.fetch_data, vecs[k].exp);
        bus.fetch_req = 1'b0;
      end
    end
  endtask

  // Load ld_words at base with stall_q[i] idle cycles before word i.
  task automatic run_load(input logic [7:0] base, input bit hold_fetch,
                          input logic [7:0] faddr, input bit start_noise);
    int          n;
    bit          bad;
    logic [15:0] pre;
    logic [7:0]  a;
    n = ld_words.size();
    bad = 1'b0;
    pre = ref_mem[faddr];
    bus.ld_start = 1'b1;
    bus.ld_base  = base;
    if (hold_fetch) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = faddr;
    end
    tick();
    bus.ld_start = 1'b0;
    chk1("start_ld_ready", bus.ld_ready, 1'b1);
    chk1("start_busy", bus.busy, 1'b1);
    chk1("start_wrap_cleared", bus.ld_wrap, 1'b0);
    if (hold_fetch) begin
      chk1("start_fetch_valid", bus.fetch_valid, 1'b1);
      chk16("start_fetch_data", bus.fetch_data, pre);
    end
    for (int i = 0; i < n; i++) begin
      for (int s = 0; s < stall_q[i]; s++) begin
        bus.ld_valid = 1'b0;
        bus.ld_data  = 16'($urandom);
        bus.ld_last  = 1'($urandom);
        if (start_noise) begin
          bus.ld_start = 1'b1;
          bus.ld_base  = 8'($urandom);
        end
        tick();
        bus.ld_start = 1'b0;
        if (!bus.ld_ready || bus.fetch_valid || bus.ld_done || !bus.busy) bad = 1'b1;
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = ld_words[i];
      bus.ld_last  = (i == n - 1);
      tick();
      a = base + i[7:0];
      ref_mem[a] = ld_words[i];
      if (bus.fetch_valid) bad = 1'b1;
      if (i != n - 1 && (!bus.ld_ready || bus.ld_done)) bad = 1'b1;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    chk1("load_phase_flags_ok", bad, 1'b0);
    chk1("done_pulse", bus.ld_done, 1'b1);
    chk1("done_ready_low", bus.ld_ready, 1'b0);
    chk1("done_busy_low", bus.busy, 1'b0);
    chk1("done_wrap", bus.ld_wrap, (int'(base) + n) >= DEPTH);
    tick();
    chk1("done_one_cycle", bus.ld_done, 1'b0);
    if (hold_fetch) begin
      chk1("post_load_fetch_valid", bus.fetch_valid, 1'b1);
      chk16("post_load_fetch_data", bus.fetch_data, ref_mem[faddr]);
    end
    bus.fetch_req = 1'b0;
  endtask

  initial begin
    logic [7:0] base;
    logic [7:0] ra;
    int         n;

    vecs.push_back('{0, 8'h00, 16'h4F10});
    vecs.push_back('{0, 8'h01, 16'h81B6});
    vecs.push_back('{0, 8'h02, 16'h1970});
    vecs.push_back('{0, 8'h03, 16'h0000});
    vecs.push_back('{1, 8'hFE, 16'hA00A});
    vecs.push_back('{1, 8'hFF, 16'hB00B});
    vecs.push_back('{1, 8'h00, 16'hC00C});
    vecs.push_back('{1, 8'h01, 16'hD00D});
    vecs.push_back('{1, 8'h02, 16'h1970});
    vecs.push_back('{1, 8'hFD, 16'h0000});
    vecs.push_back('{2, 8'h40, 16'h1111});
    vecs.push_back('{2, 8'h41, 16'h2222});
    vecs.push_back('{2, 8'h42, 16'h3333});
    vecs.push_back('{2, 8'h43, 16'h0000});

    reset_and_clear(1'b1);

    fetch_chk(8'h37, "first_fetch");
    tick();
    chk1("idle_valid_low", bus.fetch_valid, 1'b0);
    chk16("idle_data_hold", bus.fetch_data, 16'h0000);

    ld_words = '{16'h4F10, 16'h81B6, 16'h1970};
    stall_q  = '{0, 0, 0};
    run_load(8'h00, 1'b0, 8'h00, 1'b0);
    apply_table(0);

    ld_words = '{16'hA00A, 16'hB00B, 16'hC00C, 16'hD00D};
    stall_q  = '{0, 0, 0, 0};
    run_load(8'hFE, 1'b0, 8'h00, 1'b0);
    apply_table(1);
    chk1("wrap_sticky", bus.ld_wrap, 1'b1);

    // 1,0,0,1,1(last) with fetch held and ld_start noise during stalls
    ld_words = '{16'h1111, 16'h2222, 16'h3333};
    stall_q  = '{0, 2, 0};
    run_load(8'h40, 1'b1, 8'h40, 1'b1);
    apply_table(2);

    for (int r = 0; r < 20; r++) begin
      base = 8'($urandom);
      if (r % 5 == 0) base = 8'hF8 + 8'($urandom_range(0, 7));
      n = $urandom_range(1, 6);
      ld_words.delete();
      stall_q.delete();
      for (int i = 0; i < n; i++) begin
        ld_words.push_back(16'($urandom));
        stall_q.push_back($urandom_range(0, 2));
      end
      ra = 8'($urandom);
      run_load(base, 1'($urandom), ra, 1'($urandom));
      for (int i = 0; i < n; i++) fetch_chk(base + i[7:0], "rnd_loaded");
      for (int j = 0; j < 4; j++) begin
        ra = 8'($urandom);
        fetch_chk(ra, "rnd_fetch");
        tick();
        chk1("rnd_gap_valid", bus.fetch_valid, 1'b0);
        chk16("rnd_gap_hold", bus.fetch_data, ref_mem[ra]);
      end
    end

    // Reset after 2 of 5 words: partial load discarded, sweep reruns
    bus.ld_start = 1'b1;
    bus.ld_base  = 8'h10;
    tick();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 16'h5A50 + 16'(i);
      bus.ld_last  = 1'b0;
      tick();
    end
    bus.ld_valid = 1'b0;
    reset_and_clear(1'b0);
    for (int i = 0; i < DEPTH; i++) fetch_chk(8'(i), "sweep_zero");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
